// File: rtl/tone_generator.sv
// Four-bin triangle tone synthesizer. It plays one accepted note for a fixed number of
// codec sample slots and then a silent gap, paced by the codec's advance strobe.
module tone_generator #(
  parameter int unsigned PHASE_W      = 24,
  parameter int unsigned SAMPLE_W     = 24,
  parameter int unsigned INC_1        = 182889,
  parameter int unsigned INC_2        = 230428,
  parameter int unsigned INC_3        = 274024,
  parameter int unsigned INC_4        = 365778,
  parameter int unsigned NOTE_SAMPLES = 4800,
  parameter int unsigned GAP_SAMPLES  = 480
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       advance,
  input  logic                       note_valid,
  input  logic [2:0]                 note,
  output logic                       note_ready,
  output logic signed [SAMPLE_W-1:0] sample_out,
  output logic                       sample_valid,
  output logic                       busy
);

  localparam int unsigned CNT_MAX   = (NOTE_SAMPLES > GAP_SAMPLES) ? NOTE_SAMPLES : GAP_SAMPLES;
  localparam int unsigned CNT_W     = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
  localparam logic [CNT_W-1:0] NOTE_LAST = CNT_W'(NOTE_SAMPLES - 1);
  localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'((GAP_SAMPLES == 0) ? 0 : GAP_SAMPLES - 1);

  typedef enum logic [1:0] {IDLE, PLAY, GAP} state_t;

  state_t                       state, state_d;
  logic [PHASE_W-1:0]           phase, phase_d;
  logic [PHASE_W-1:0]           inc, inc_d;
  logic [CNT_W-1:0]             count, count_d;
  logic signed [SAMPLE_W-1:0]   sample_d;
  logic                         valid_d;
  logic [PHASE_W-1:0]           note_inc;

  // Triangle from the top 16 phase bits, centred on zero and left-justified in the sample.
  function automatic logic signed [SAMPLE_W-1:0] tri_wave(input logic [PHASE_W-1:0] ph);
    logic [15:0]        u;
    logic [14:0]        t;
    logic signed [15:0] s16;
    u   = ph[PHASE_W-1 -: 16];
    t   = u[15] ? ~u[14:0] : u[14:0];
    s16 = signed'({1'b0, t}) - 16'sd16384;
    return SAMPLE_W'(s16) <<< (SAMPLE_W - 16);
  endfunction

  always_comb begin
    note_inc = '0;
    case (note)
      3'd1:    note_inc = PHASE_W'(INC_1);
      3'd2:    note_inc = PHASE_W'(INC_2);
      3'd3:    note_inc = PHASE_W'(INC_3);
      3'd4:    note_inc = PHASE_W'(INC_4);
      default: note_inc = '0;
    endcase
  end

  assign note_ready = (state == IDLE);
  assign busy       = ~note_ready;

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_d;
  end

  always_comb begin
    state_d = state;
    case (state)
      IDLE: if (note_valid) state_d = PLAY;
      PLAY: if (advance && count == NOTE_LAST) state_d = (GAP_SAMPLES == 0) ? IDLE : GAP;
      GAP:  if (advance && count == GAP_LAST) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Datapath next values; the count restarts whenever the state changes.
  always_comb begin
    phase_d  = phase;
    inc_d    = inc;
    count_d  = count;
    sample_d = sample_out;
    valid_d  = advance;
    if (advance) sample_d = '0;
    case (state)
      IDLE: begin
        if (note_valid) begin
          inc_d   = note_inc;
          phase_d = '0;
          count_d = '0;
        end
      end
      PLAY: begin
        if (advance) begin
          if (inc != '0) sample_d = tri_wave(phase);
          phase_d = phase + inc;
          count_d = (count == NOTE_LAST) ? '0 : count + 1'b1;
        end
      end
      GAP: begin
        if (advance) count_d = (count == GAP_LAST) ? '0 : count + 1'b1;
      end
      default: count_d = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      phase        <= '0;
      inc          <= '0;
      count        <= '0;
      sample_out   <= '0;
      sample_valid <= 1'b0;
    end else begin
      phase        <= phase_d;
      inc          <= inc_d;
      count        <= count_d;
      sample_out   <= sample_d;
      sample_valid <= valid_d;
    end
  end

endmodule

// File: tb/tb_tone_generator.sv
// Bench for tone_generator: the reference model expands each accepted note into its whole
// sample sequence; a monitor compares every presented sample against the scoreboard queue.
module tb_tone_generator;

  localparam int unsigned PHASE_W = 24;
  localparam int unsigned SAMPLE_W = 24;
  localparam int unsigned INC_1 = 1 << 20;
  localparam int unsigned INC_2 = 230428;
  localparam int unsigned INC_3 = 274024;
  localparam int unsigned INC_4 = 365778;
  localparam int unsigned NOTE_N = 20;
  localparam int unsigned GAP_N = 2;

  logic clk;
  logic reset;
  logic advance;
  logic note_valid;
  logic [2:0] note;
  logic note_ready;
  logic signed [SAMPLE_W-1:0] sample_out;
  logic sample_valid;
  logic busy;

  int pass_cnt = 0;
  int total_cnt = 0;

  int pending[$];
  int expq[$];
  bit rst_seen = 1'b0;

  tone_generator #(
    .PHASE_W(PHASE_W), .SAMPLE_W(SAMPLE_W),
    .INC_1(INC_1), .INC_2(INC_2), .INC_3(INC_3), .INC_4(INC_4),
    .NOTE_SAMPLES(NOTE_N), .GAP_SAMPLES(GAP_N)
  ) dut (
    .clk(clk), .reset(reset), .advance(advance), .note_valid(note_valid), .note(note),
    .note_ready(note_ready), .sample_out(sample_out), .sample_valid(sample_valid), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Expected k-th sample of a note, straight from the phase arithmetic.
  function automatic int exp_sample(input int code, input int k);
    longint inc;
    longint ph;
    int u;
    int t;
    case (code)
      1: inc = INC_1;
      2: inc = INC_2;
      3: inc = INC_3;
      4: inc = INC_4;
      default: inc = 0;
    endcase
    if (inc == 0) return 0;
    ph = (longint'(k) * inc) % (64'sd1 << PHASE_W);
    u = int'(ph >> (PHASE_W - 16));
    t = (u >= 32768) ? 65535 - u : u;
    return (t - 16384) * 256;
  endfunction

  task automatic check(input string name, input int act, input int exp);
    total_cnt++;
    if (act == exp) pass_cnt++;
    else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
  endtask

  // Reference model: a pending list of upcoming samples; busy means the list is non-empty.
  always @(posedge clk) begin
    if (reset) begin
      pending.delete();
      expq.delete();
      rst_seen = 1'b1;
    end else begin
      bit idle;
      idle = (pending.size() == 0);
      rst_seen = 1'b0;
      if (advance) expq.push_back(idle ? 0 : pending.pop_front());
      if (note_valid && idle) begin
        for (int k = 0; k < int'(NOTE_N); k++) pending.push_back(exp_sample(int'(note), k));
        for (int g = 0; g < int'(GAP_N); g++) pending.push_back(0);
      end
    end
  end

  // Monitor, half a cycle after the active edge.
  always @(negedge clk) begin
    check("busy", int'(busy), int'(pending.size() != 0));
    check("note_ready", int'(note_ready), int'(pending.size() == 0));
    check("sample_valid", int'(sample_valid), int'(expq.size() != 0));
    if (sample_valid && expq.size() != 0) check("sample_out", int'(sample_out), expq.pop_front());
    if (rst_seen) check("reset_sample", int'(sample_out), 0);
  end

  task automatic drive(input logic a, input logic v, input logic [2:0] n, input logic r);
    advance = a;
    note_valid = v;
    note = n;
    reset = r;
    @(posedge clk);
    #1;
  endtask

  initial begin
    advance = 1'b0;
    note_valid = 1'b0;
    note = 3'd0;
    reset = 1'b1;
    @(posedge clk);
    #1;
    drive(0, 0, 0, 1);
    drive(0, 0, 0, 0);

    // Reset held three cycles in the middle of a note
    drive(0, 1, 3'd1, 0);
    for (int i = 0; i < 3; i++) drive(1, 0, 0, 0);
    for (int i = 0; i < 3; i++) drive(1'(i), 1, 3'd2, 1);
    drive(0, 0, 0, 0);
    drive(1, 0, 0, 0);
    drive(0, 0, 0, 0);

    // Bin 1 across a full phase wrap, advance every other cycle
    drive(0, 1, 3'd1, 0);
    for (int i = 0; i < int'(NOTE_N + GAP_N); i++) begin
      drive(1, 0, 0, 0);
      drive(0, 0, 0, 0);
    end

    // Advance coincident with accept, then a request held while busy
    drive(1, 1, 3'd4, 0);
    for (int i = 0; i < int'(NOTE_N + GAP_N) + 2; i++) drive(1, 1, 3'd3, 0);
    for (int i = 0; i < int'(NOTE_N + GAP_N); i++) drive(1, 0, 0, 0);

    // Out-of-range code plays silence for a full note
    drive(0, 1, 3'd6, 0);
    for (int i = 0; i < int'(NOTE_N + GAP_N) + 1; i++) drive(1, 0, 0, 0);

    for (int i = 0; i < 4000; i++)
      drive(1'($urandom_range(0, 1)), 1'(($urandom % 4) == 0), 3'($urandom % 8),
            1'(($urandom % 300) == 0));

    drive(0, 0, 0, 0);
    drive(0, 0, 0, 0);
    check("queue_drained", expq.size(), 0);
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
